code_entry: RTL and testbench

- Keypad digit accumulator directly upstream of compare_codes.
- Collects four BCD keypresses into the 16-bit logical input_code, MSD first.
- On ENTER with exactly four digits, presents the code to the comparator with a one-cycle code_valid strobe.
- Also handles clear, invalid keys, an inactivity timeout and a downstream enable.

---
 rtl/code_entry_pkg.sv | 44 ++++
 rtl/code_entry_inactivity_timer.sv | 32 +++
 rtl/code_entry.sv | 117 +++++++++++
 tb/tb_code_entry.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/code_entry_pkg.sv
// Shared definitions for the keypad code-entry path.
//   - Key encodings and key classification helper
//   - Code geometry (digit count, code width)
//   - Entry FSM state type
//   - STORED_MASK, the significant-bit mask of the stored code, shared with compare_codes
package code_entry_pkg;

    localparam int unsigned CODE_DIGITS = 4;
    localparam int unsigned CODE_W      = 16;

    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    localparam logic [CODE_W-1:0] STORED_MASK = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_FULL,
        ST_SUBMIT
    } entry_state_t;

    typedef enum logic [1:0] {
        KK_DIGIT,
        KK_INVALID,
        KK_CLEAR,
        KK_ENTER
    } key_kind_t;

    function automatic key_kind_t classify_key(input logic [3:0] key);
        key_kind_t kind;
        if (key <= 4'h9) begin
            kind = KK_DIGIT;
        end else if (key == KEY_CLEAR) begin
            kind = KK_CLEAR;
        end else if (key == KEY_ENTER) begin
            kind = KK_ENTER;
        end else begin
            kind = KK_INVALID;
        end
        return kind;
    endfunction

endpackage

// File: rtl/code_entry_inactivity_timer.sv
// Saturating inactivity timer.
//   clk     : system clock
//   clear   : synchronous clear to zero (highest priority)
//   enable  : count while high; holds otherwise
//   expired : high while enabled and the count has reached LIMIT-1
// The count stops at LIMIT-1, so it never wraps regardless of how long
// the owner leaves it enabled.
module inactivity_timer #(
    parameter int unsigned LIMIT = 1000,
    parameter int unsigned W     = 16
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + W'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/code_entry.sv
// Keypad digit accumulator feeding compare_codes.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   entry_en    : downstream permit; low discards the entry and ignores keys
//   key_valid   : one-cycle key strobe
//   key_value   : 0-9 digit, A-D invalid, E clear, F enter
//   input_code  : {D3,D2,D1,D0}, most significant digit entered first
//   code_valid  : one-cycle strobe, input_code is a submitted code
//   digit_count : digits held, 0..4
//   entry_error : one-cycle strobe on a rejected key
//   timeout     : one-cycle strobe when the entry is dropped for inactivity
module code_entry
    import code_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TMR_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              entry_en,
    input  logic              key_valid,
    input  logic [3:0]        key_value,
    output logic [CODE_W-1:0] input_code,
    output logic              code_valid,
    output logic [2:0]        digit_count,
    output logic              entry_error,
    output logic              timeout
);

    localparam logic [2:0] FULL_COUNT = 3'(CODE_DIGITS);

    entry_state_t state;
    key_kind_t    kind;
    logic         tmr_clear;
    logic         tmr_run;
    logic         tmr_expired;

    assign kind = classify_key(key_value);

    // Any key, any discard, and the non-counting states all restart the
    // timer; it only advances with a partial or full entry held.
    assign tmr_run   = (state == ST_ENTRY) || (state == ST_FULL);
    assign tmr_clear = rst || !entry_en || key_valid || !tmr_run || tmr_expired;

    inactivity_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TMR_W)
    ) u_timer (
        .clk     (clk),
        .clear   (tmr_clear),
        .enable  (tmr_run),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            input_code  <= '0;
            digit_count <= '0;
            code_valid  <= 1'b0;
            entry_error <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            code_valid  <= 1'b0;
            entry_error <= 1'b0;
            timeout     <= 1'b0;

            // entry_en low discards every cycle; code_valid already raised
            // for a SUBMIT cycle still completes since it is a registered strobe.
            if (!entry_en || (state == ST_SUBMIT)) begin
                state       <= ST_IDLE;
                input_code  <= '0;
                digit_count <= '0;
            end else if (key_valid) begin
                unique case (kind)
                    KK_DIGIT: begin
                        if (state == ST_FULL) begin
                            entry_error <= 1'b1;
                        end else begin
                            input_code  <= {input_code[CODE_W-5:0], key_value};
                            digit_count <= digit_count + 3'd1;
                            state       <= (digit_count == FULL_COUNT - 3'd1) ? ST_FULL : ST_ENTRY;
                        end
                    end
                    KK_INVALID: begin
                        entry_error <= 1'b1;
                    end
                    KK_CLEAR: begin
                        state       <= ST_IDLE;
                        input_code  <= '0;
                        digit_count <= '0;
                    end
                    KK_ENTER: begin
                        if (state == ST_FULL) begin
                            state      <= ST_SUBMIT;
                            code_valid <= 1'b1;
                        end else begin
                            entry_error <= 1'b1;
                            state       <= ST_IDLE;
                            input_code  <= '0;
                            digit_count <= '0;
                        end
                    end
                    default: begin
                        entry_error <= 1'b1;
                    end
                endcase
            end else if (tmr_expired) begin
                state       <= ST_IDLE;
                input_code  <= '0;
                digit_count <= '0;
                timeout     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_code_entry.sv
module tb_code_entry;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        entry_en = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_value = 4'h0;
    logic [15:0] input_code;
    logic        code_valid;
    logic [2:0]  digit_count;
    logic        entry_error;
    logic        timeout;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    code_entry #(
        .TIMEOUT_CYCLES (TO),
        .TMR_W          (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .entry_en    (entry_en),
        .key_valid   (key_valid),
        .key_value   (key_value),
        .input_code  (input_code),
        .code_valid  (code_valid),
        .digit_count (digit_count),
        .entry_error (entry_error),
        .timeout     (timeout)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The entry is a list of digits; a submitted code is shown for one
    // cycle and then discarded; 'quiet' counts key-free cycles with digits held.
    logic [3:0] digits[$];
    bit         submitted = 0;
    int         quiet = 0;
    bit         m_cv = 0, m_err = 0, m_to = 0;
    bit         model_live = 0;

    function automatic logic [15:0] model_code();
        logic [15:0] c = '0;
        foreach (digits[i]) c = (c << 4) | 16'(digits[i]);
        return c;
    endfunction

    always @(posedge clk) begin
        m_cv = 0; m_err = 0; m_to = 0;
        if (rst || !entry_en || submitted) begin
            digits.delete();
            submitted = 0;
            quiet = 0;
        end else if (key_valid) begin
            quiet = 0;
            if (key_value <= 9) begin
                if (digits.size() < 4) digits.push_back(key_value);
                else m_err = 1;
            end else if (key_value == 4'hE) begin
                digits.delete();
            end else if (key_value == 4'hF) begin
                if (digits.size() == 4) begin
                    submitted = 1;
                    m_cv = 1;
                end else begin
                    m_err = 1;
                    digits.delete();
                end
            end else begin
                m_err = 1;
            end
        end else if (digits.size() > 0) begin
            if (quiet == int'(TO) - 1) begin
                digits.delete();
                quiet = 0;
                m_to = 1;
            end else begin
                quiet++;
            end
        end
        model_live = 1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("input_code", input_code, model_code());
            chk("digit_count", 16'(digit_count), 16'(digits.size()));
            chk("code_valid", 16'(code_valid), 16'(m_cv));
            chk("entry_error", 16'(entry_error), 16'(m_err));
            chk("timeout", 16'(timeout), 16'(m_to));
            chk("strobe_excl", 16'(int'(code_valid) + int'(entry_error) + int'(timeout) <= 1), 16'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_value = k;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        int p;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_code", input_code, 16'h0000);
        chk("rst_count", 16'(digit_count), 16'd0);
        rst = 1'b0;

        // 9,0,7,0,ENTER
        press(4'h9); press(4'h0); press(4'h7); press(4'h0);
        chk("t1_code", input_code, 16'h9070);
        chk("t1_count", 16'(digit_count), 16'd4);
        press(4'hF);
        chk("t1_cv", 16'(code_valid), 16'd1);
        chk("t1_cv_code", input_code, 16'h9070);
        tick();
        chk("t1_cv_drop", 16'(code_valid), 16'd0);
        chk("t1_code_clr", input_code, 16'h0000);
        chk("t1_count_clr", 16'(digit_count), 16'd0);

        // 1,2,ENTER
        press(4'h1); press(4'h2); press(4'hF);
        chk("t2_err", 16'(entry_error), 16'd1);
        chk("t2_cv", 16'(code_valid), 16'd0);
        chk("t2_count", 16'(digit_count), 16'd0);
        chk("t2_code", input_code, 16'h0000);

        // overflow digit, CLEAR, invalid key
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        chk("t3_err", 16'(entry_error), 16'd1);
        chk("t3_code", input_code, 16'h1234);
        press(4'hE);
        chk("t3_clr_code", input_code, 16'h0000);
        chk("t3_clr_err", 16'(entry_error), 16'd0);
        press(4'hB);
        chk("t3_inv_err", 16'(entry_error), 16'd1);

        // timeout exactly TO cycles after the key edge
        press(4'h7);
        for (int i = 1; i < int'(TO); i++) begin
            tick();
            chk("t4_no_to", 16'(timeout), 16'd0);
        end
        tick();
        chk("t4_to", 16'(timeout), 16'd1);
        chk("t4_count", 16'(digit_count), 16'd0);
        // key landing on the expiry cycle wins
        press(4'h7);
        for (int i = 1; i < int'(TO); i++) tick();
        press(4'h3);
        chk("t4b_no_to", 16'(timeout), 16'd0);
        chk("t4b_count", 16'(digit_count), 16'd2);
        press(4'hE);

        // entry_en drop
        press(4'h9); press(4'h0); press(4'h7);
        entry_en = 1'b0;
        tick();
        chk("t5_code", input_code, 16'h0000);
        press(4'h1);
        chk("t5_ign_count", 16'(digit_count), 16'd0);
        chk("t5_ign_err", 16'(entry_error), 16'd0);
        entry_en = 1'b1;
        press(4'h9); press(4'h0); press(4'h7); press(4'h1); press(4'hF);
        chk("t5_cv", 16'(code_valid), 16'd1);
        chk("t5_code2", input_code, 16'h9071);
        tick();

        // reset during SUBMIT
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hF);
        chk("t6_cv", 16'(code_valid), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_cv_rst", 16'(code_valid), 16'd0);
        chk("t6_code_rst", input_code, 16'h0000);
        chk("t6_count_rst", 16'(digit_count), 16'd0);

        // randomized traffic; key density varies so timeouts also occur
        p = 40;
        for (int c = 0; c < 4000; c++) begin
            if (c % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 4;
                    1: p = 35;
                    default: p = 80;
                endcase
            end
            rst       = ($urandom_range(0, 199) == 0);
            entry_en  = ($urandom_range(0, 99) < 96);
            key_valid = ($urandom_range(0, 99) < p);
            begin
                int r = $urandom_range(0, 99);
                if (r < 70)      key_value = 4'($urandom_range(0, 9));
                else if (r < 82) key_value = 4'hF;
                else if (r < 90) key_value = 4'hE;
                else             key_value = 4'($urandom_range(10, 13));
            end
            tick();
        end
        rst = 1'b0;
        key_valid = 1'b0;
        entry_en = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
